// File: rtl/svn_pkg.sv
// svn_pkg: shared segment patterns, code constants and FSM states for the seven-segment receiver.
package svn_pkg;
  localparam int STABLE_CYC_DEF = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  function automatic logic [2:0] low_idx(input logic [7:0] an);
    low_idx = 3'd0;
    for (int i = 0; i < 8; i++) if (!an[i]) low_idx = 3'(i);
  endfunction
endpackage

// File: rtl/svn_pat_enc.sv
// svn_pat_enc: active-low segment pattern {CA..CG} to digit code, with legal flag.
module svn_pat_enc
  import svn_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       legal
);
  always_comb begin
    code = BLANK_CODE;
    legal = 1'b1;
    case (seg)
      SEG_0: code = 4'd0;
      SEG_1: code = 4'd1;
      SEG_2: code = 4'd2;
      SEG_3: code = 4'd3;
      SEG_4: code = 4'd4;
      SEG_5: code = 4'd5;
      SEG_6: code = 4'd6;
      SEG_7: code = 4'd7;
      SEG_8: code = 4'd8;
      SEG_9: code = 4'd9;
      SEG_BLANK: code = BLANK_CODE;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/svn_rcvr.sv
// svn_rcvr: recovers digit codes and decimal points from observed multiplexed seven-segment lines.
module svn_rcvr
  import svn_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        DP,
  input  logic [7:0]  AN,
  output logic [31:0] digits,
  output logic [7:0]  dps,
  output logic [7:0]  digit_vld,
  output logic        upd,
  output logic [2:0]  upd_idx,
  output logic        pat_err,
  output logic        an_err
);
  localparam logic [7:0] STABLE = 8'(STABLE_CYC);
  logic [15:0] sync1, s, prev;
  state_t state, state_n;
  logic [7:0] count, count_n;
  logic [7:0] an_low;
  logic [3:0] code;
  logic [2:0] idx;
  logic legal, changed, idle_an, multi, eval;
  svn_pat_enc u_enc (.seg(s[7:1]), .code(code), .legal(legal));
  assign an_low = ~s[15:8];
  assign idle_an = an_low == 8'd0;
  assign multi = (an_low & (an_low - 8'd1)) != 8'd0;
  assign changed = s != prev;
  assign idx = low_idx(s[15:8]);
  assign eval = state == SETTLE && !changed && count == STABLE;
  always_comb begin
    state_n = state;
    count_n = count;
    if (changed) begin
      state_n = idle_an ? IDLE : SETTLE;
      count_n = idle_an ? 8'd0 : 8'd1;
    end else if (state == SETTLE) begin
      state_n = count == STABLE ? HOLD : SETTLE;
      count_n = count == STABLE ? count : count + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      s <= '1;
      prev <= '1;
      state <= IDLE;
      count <= 8'd0;
      digits <= 32'hFFFF_FFFF;
      dps <= 8'd0;
      digit_vld <= 8'd0;
      upd <= 1'b0;
      upd_idx <= 3'd0;
      pat_err <= 1'b0;
      an_err <= 1'b0;
    end else begin
      sync1 <= {AN, CA, CB, CC, CD, CE, CF, CG, DP};
      s <= sync1;
      prev <= s;
      state <= state_n;
      count <= count_n;
      upd <= eval && !multi && legal;
      pat_err <= eval && !multi && !legal;
      an_err <= eval && multi;
      if (eval && !multi && legal) begin
        digits[{idx, 2'b00} +: 4] <= code;
        dps[idx] <= ~s[0];
        digit_vld[idx] <= 1'b1;
        upd_idx <= idx;
      end
    end
  end
endmodule

// File: tb/tb_svn_rcvr.sv
// tb_svn_rcvr: directed and random stimulus checked against a run-length behavioural model.
module tb_svn_rcvr;
  localparam int SC = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] an_in = 8'hFF;
  logic [6:0] seg_in = 7'h7F;
  logic dp_in = 1'b1;
  logic [31:0] digits;
  logic [7:0] dps, digit_vld;
  logic upd, pat_err, an_err;
  logic [2:0] upd_idx;
  int n_tests = 0, n_fail = 0;
  int c_upd = 0, c_pat = 0, c_an = 0;
  logic [6:0] pat_tab [11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111111};

  svn_rcvr #(.STABLE_CYC(SC)) dut (
    .clk(clk), .rst(rst),
    .CA(seg_in[6]), .CB(seg_in[5]), .CC(seg_in[4]), .CD(seg_in[3]),
    .CE(seg_in[2]), .CF(seg_in[1]), .CG(seg_in[0]), .DP(dp_in), .AN(an_in),
    .digits(digits), .dps(dps), .digit_vld(digit_vld), .upd(upd),
    .upd_idx(upd_idx), .pat_err(pat_err), .an_err(an_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] seg);
    lookup = -1;
    for (int k = 0; k < 11; k++) if (seg == pat_tab[k]) lookup = (k < 10) ? k : 15;
  endfunction

  // Model: S is the pin vector delayed two edges; a vector that has stood still
  // for exactly SC+1 edges is evaluated and its result appears on the next edge.
  bit armed = 0;
  logic [15:0] m_last, m_s;
  int m_run;
  logic [31:0] e_digits;
  logic [7:0] e_dps, e_vld;
  logic e_upd, e_pat, e_an;
  logic [2:0] e_idx;
  always @(posedge clk) begin
    if (rst) begin
      armed = 1; m_last = '1; m_s = '1; m_run = 1;
      e_digits = 32'hFFFF_FFFF; e_dps = 0; e_vld = 0;
      e_upd = 0; e_pat = 0; e_an = 0; e_idx = 0;
    end else if (armed) begin
      e_upd = 0; e_pat = 0; e_an = 0;
      if (m_run == SC + 1 && m_s[15:8] != 8'hFF) begin
        if ($countones(~m_s[15:8]) > 1) e_an = 1;
        else begin
          int i, c;
          i = 0;
          for (int b = 0; b < 8; b++) if (!m_s[8 + b]) i = b;
          c = lookup(m_s[7:1]);
          if (c < 0) e_pat = 1;
          else begin
            e_upd = 1; e_idx = 3'(i);
            e_digits[i*4 +: 4] = 4'(c);
            e_dps[i] = ~m_s[0];
            e_vld[i] = 1'b1;
          end
        end
      end
      m_run = (m_last == m_s) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      m_s = m_last;
      m_last = {an_in, seg_in, dp_in};
    end
  end

  always @(negedge clk) if (armed) begin
    chk("digits", digits, e_digits);
    chk("dps", {24'd0, dps}, {24'd0, e_dps});
    chk("digit_vld", {24'd0, digit_vld}, {24'd0, e_vld});
    chk("upd", {31'd0, upd}, {31'd0, e_upd});
    chk("pat_err", {31'd0, pat_err}, {31'd0, e_pat});
    chk("an_err", {31'd0, an_err}, {31'd0, e_an});
    if (e_upd) chk("upd_idx", {29'd0, upd_idx}, {29'd0, e_idx});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      c_upd += int'(upd); c_pat += int'(pat_err); c_an += int'(an_err);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] sg, input logic d);
    an_in = a; seg_in = sg; dp_in = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, digits, 32'hFFFF_FFFF);
    chk({tag, "_dps_vld"}, {16'd0, dps, digit_vld}, 32'd0);
    chk({tag, "_pulses"}, {29'd0, upd, pat_err, an_err}, 32'd0);
    chk({tag, "_upd_idx"}, {29'd0, upd_idx}, 32'd0);
  endtask

  initial begin
    int u0, p0, a0;
    tick(2);
    chk_reset_vals("rst");
    rst = 0;
    drive(8'hFE, 7'b0000110, 1'b0);
    tick(6);
    chk("lat_before", {31'd0, upd}, 32'd0);
    tick(1);
    chk("lat_upd", {31'd0, upd}, 32'd1);
    chk("lat_idx", {29'd0, upd_idx}, 32'd0);
    chk("lat_digit0", {28'd0, digits[3:0]}, 32'd3);
    chk("lat_dp0", {31'd0, dps[0]}, 32'd1);
    chk("lat_vld", {24'd0, digit_vld}, 32'h01);
    tick(3);
    u0 = c_upd;
    for (int i = 0; i < 8; i++) begin
      drive(~(8'd1 << i), pat_tab[7 - i], 1'b1);
      tick(10);
    end
    chk("scan_upds", c_upd - u0, 8);
    chk("scan_digits", digits, 32'h0123_4567);
    chk("scan_vld", {24'd0, digit_vld}, 32'hFF);
    u0 = c_upd; p0 = c_pat;
    drive(8'hFB, 7'b1111111, 1'b1);
    tick(10);
    chk("blank_upd", c_upd - u0, 1);
    chk("blank_code", {28'd0, digits[11:8]}, 32'hF);
    u0 = c_upd;
    drive(8'hFB, 7'b1010101, 1'b1);
    tick(10);
    chk("illegal_pat", c_pat - p0, 1);
    chk("illegal_noupd", c_upd - u0, 0);
    chk("illegal_keep", {28'd0, digits[11:8]}, 32'hF);
    u0 = c_upd; p0 = c_pat; a0 = c_an;
    drive(8'hFC, 7'b1001111, 1'b0);
    tick(10);
    chk("multi_an_err", c_an - a0, 1);
    chk("multi_noupd", c_upd - u0, 0);
    chk("multi_nopat", c_pat - p0, 0);
    drive(8'hFE, 7'b0000000, 1'b0);
    tick(10);
    u0 = c_upd; p0 = c_pat; a0 = c_an;
    drive(8'hFE, 7'b0000001, 1'b0);
    tick(3);
    drive(8'hFE, 7'b0000000, 1'b0);
    tick(4);
    chk("glitch_quiet", (c_upd - u0) + (c_pat - p0) + (c_an - a0), 0);
    tick(5);
    chk("glitch_return", c_upd - u0, 1);
    drive(8'hF7, 7'b1001111, 1'b0);
    tick(5);
    rst = 1;
    tick(1);
    chk_reset_vals("midrst");
    rst = 0;
    u0 = c_upd;
    tick(6);
    chk("midrst_noupd", c_upd - u0, 0);
    tick(1);
    chk("midrst_new_window", {31'd0, upd}, 32'd1);
    repeat (300) begin
      int r;
      logic [7:0] a;
      logic [6:0] sg;
      r = $urandom_range(0, 99);
      a = ~(8'd1 << $urandom_range(0, 7));
      sg = pat_tab[$urandom_range(0, 10)];
      if (r >= 70 && r < 80) begin
        sg = 7'($urandom);
        while (lookup(sg) >= 0) sg = 7'($urandom);
      end else if (r >= 80 && r < 90) begin
        a = 8'($urandom);
        while ($countones(~a) < 2) a = 8'($urandom);
      end else if (r >= 90) a = 8'hFF;
      drive(a, sg, 1'($urandom));
      if ($urandom_range(0, 99) < 3) begin
        rst = 1;
        tick(1);
        rst = 0;
      end
      tick($urandom_range(1, 12));
    end
    tick(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/svn_rcvr.md
SVN_RCVR -- requirements
Module: svn_rcvr

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter STABLE_CYC, default 4, range 2..255: consecutive sampled cycles a display vector must hold before commit.
REQ-003 clk  input  1  sole clock; all flops rise-edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 CA,CB,CC,CD,CE,CF,CG  input  1 each  observed segment lines, active-low (0 = lit).
REQ-006 DP  input  1  observed decimal-point line, active-low.
REQ-007 AN  input  8  observed digit enables, active-low, one-cold when a digit is driven.
REQ-008 digits  output  32  recovered codes, digit i at [4i+3:4i].
REQ-009 dps  output  8  recovered decimal points, 1 = lit.
REQ-010 digit_vld  output  8  bit i = digit i committed at least once since reset.
REQ-011 upd  output  1  one-cycle pulse on each commit.
REQ-012 upd_idx  output  3  index of committed digit, valid while upd=1.
REQ-013 pat_err  output  1  one-cycle pulse: stable segment pattern not in code table.
REQ-014 an_err  output  1  one-cycle pulse: stable AN vector has more than one low bit.

Function
REQ-015 All inputs SHALL pass through a 2-flop synchronizer; the second-stage vector S = {AN, CA..CG, DP} is the only value used downstream.
REQ-016 Code table {CA..CG}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank 1111111 -> code 4'hF; any other pattern is illegal.
REQ-017 FSM states: IDLE, SETTLE, HOLD.
REQ-018 IDLE: entered when S.AN is all-high; no counting, no commit.
REQ-019 Any cycle where S differs from its previous-cycle value SHALL move to SETTLE with count=1, or to IDLE if S.AN is all-high.
REQ-020 SETTLE: count increments each cycle S is unchanged; on reaching STABLE_CYC the vector is evaluated once and the FSM moves to HOLD.
REQ-021 Evaluation, one-cold AN index i with legal pattern: digits[i] <= code, dps[i] <= ~DP, digit_vld[i] <= 1, upd=1, upd_idx=i.
REQ-022 Evaluation, one-cold AN with illegal pattern: pat_err=1; digit i storage and digit_vld unchanged.
REQ-023 Evaluation, multi-low AN: an_err=1; no storage change; pat_err not asserted.
REQ-024 HOLD: no further commit or error pulse until S changes (REQ-019); a repeated identical vector after a change SHALL commit again.
REQ-025 Latency: pins changed and held from edge k SHALL produce upd high in the cycle following edge k+STABLE_CYC+2.
REQ-026 Outputs registered; upd, pat_err, an_err never high two consecutive cycles.
REQ-027 Counter saturates at STABLE_CYC; no wrap in HOLD.

Reset
REQ-028 On rst: digits=32'hFFFF_FFFF, dps=0, digit_vld=0, upd=0, upd_idx=0, pat_err=0, an_err=0, FSM=IDLE, count=0, synchronizer flops=all-ones.
REQ-029 rst asserted mid-SETTLE SHALL abort the pending commit; no pulse follows reset deassertion until a full new STABLE_CYC window elapses.

Structure
REQ-030 Shared package svn_pkg SHALL hold the eleven segment pattern constants, BLANK_CODE=4'hF, STABLE_CYC default, and the FSM state enum.
REQ-031 One sub-module svn_pat_enc: combinational 7-bit pattern -> 4-bit code plus legal flag, instantiated once.

Verification
REQ-032 Reset then AN=8'hFE, segs=0000110, DP=0 held, STABLE_CYC=4 -> upd after edge 6, upd_idx=0, digits[3:0]=3, dps[0]=1, digit_vld=8'h01.
REQ-033 Scan digits 0..7 with values 7,6,5,4,3,2,1,0, 10 cycles each -> eight upd pulses, digits=32'h0123_4567, digit_vld=8'hFF.
REQ-034 AN=8'hFB, segs=1111111 -> digits[11:8]=F, upd once; segs=1010101 -> pat_err once, digits[11:8] stays F.
REQ-035 AN=8'hFC held -> an_err once, no upd; segment glitch lasting 3 cycles with STABLE_CYC=4 -> no upd, no error.
REQ-036 Assert rst at count=3 of a SETTLE window -> no upd; outputs equal REQ-028 values.
